// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - byte-stream program loader that writes words into instruction memory
module inst_mem_loader #(
    parameter int DataWidth = 32,
    parameter int MemBytes  = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Start,
    input  logic [7:0]           RxData,
    input  logic                 RxValid,
    output logic                 RxReady,
    output logic                 MemWrEn,
    output logic [DataWidth-1:0] MemWrAddr,
    output logic [31:0]          MemWrData,
    output logic                 CpuHold,
    output logic                 Done,
    output logic                 Error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Largest word count that fits in the memory; one extra bit so the
    // compare against a 16-bit length never truncates.
    localparam logic [16:0] MaxWords = 17'(MemBytes / 4);

    state_t         state;
    state_t         state_next;

    logic [7:0]     len_lo;
    logic [15:0]    word_cnt;
    logic [15:0]    word_idx;
    logic [1:0]     byte_idx;
    logic [23:0]    word_buf;
    logic           accept;
    logic [15:0]    len_full;
    logic           len_too_big;
    logic           last_word;

    assign accept      = RxValid & RxReady;
    assign len_full    = {RxData, len_lo};
    assign len_too_big = ({1'b0, len_full} > MaxWords);
    assign last_word   = ((word_idx + 16'd1) == word_cnt);

    // State register; reset abandons any load in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded outputs; outputs come straight from the
    // state so they take their reset values as soon as rst_n drops.
    always_comb begin
        state_next = state;
        RxReady    = 1'b0;
        MemWrEn    = 1'b0;
        CpuHold    = 1'b1;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                CpuHold = 1'b0;
                if (Start) begin
                    state_next = LEN_LO;
                end
            end
            LEN_LO: begin
                RxReady = 1'b1;
                if (RxValid) begin
                    state_next = LEN_HI;
                end
            end
            LEN_HI: begin
                RxReady = 1'b1;
                if (RxValid) begin
                    if (len_full == 16'd0) begin
                        state_next = DONE;
                    end else if (len_too_big) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                RxReady = 1'b1;
                if (RxValid && (byte_idx == 2'd3)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                MemWrEn = 1'b1;
                if (last_word) begin
                    state_next = DONE;
                end else begin
                    state_next = DATA;
                end
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                CpuHold    = 1'b0;
            end
        endcase
    end

    // Length capture, word assembly and write-port registers. The write
    // address/data are loaded on the edge entering WRITE and then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo    <= '0;
            word_cnt  <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            MemWrAddr <= '0;
            MemWrData <= '0;
            Error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        Error    <= 1'b0;
                        word_cnt <= '0;
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_lo <= RxData;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        word_cnt <= len_full;
                        if (len_too_big) begin
                            Error <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= RxData;
                            2'd1: word_buf[15:8]  <= RxData;
                            2'd2: word_buf[23:16] <= RxData;
                            default: begin
                                MemWrData <= {RxData, word_buf};
                                MemWrAddr <= DataWidth'({word_idx, 2'b00});
                            end
                        endcase
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + 16'd1;
                    byte_idx <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
